// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and default sizes for the adder/subtractor
// operand sequencer and its optional overflow counter.
package addsub_pkg;

  // Sequencer states, plain 2-bit binary code.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  // Default operand/result width; must match the attached adder/subtractor.
  localparam int DEF_WIDTH = 4;

  // Default overflow counter width.
  localparam int DEF_CNT_W = 8;

endpackage : addsub_pkg

// File: rtl/addsub_ovf_counter.sv
// addsub_ovf_counter: saturating event counter with synchronous clear.
// Clear wins over a simultaneous increment; the count never wraps.
module addsub_ovf_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count increments, holding at the all-ones value; clear has priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule : addsub_ovf_counter

// File: rtl/addsub_op_sequencer.sv
// addsub_op_sequencer: accepts operand pairs, holds them on the inputs of an
// external combinational adder/subtractor for one settling cycle, captures
// Sub/Cout/V and offers them downstream over valid/ready.
// Optional feature macro: ADDSUB_OVF_COUNT_EN (saturating signed-overflow count).
module addsub_op_sequencer
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  // operand side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  // adder/subtractor side
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  input  logic [WIDTH-1:0] au_sub,
  input  logic             au_cout,
  input  logic             au_v,
  // result side
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic             res_v,
  // overflow statistics
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  state_t state;
  state_t state_next;
  logic   load;
  logic   capture;

  // State register; reset discards any in-flight transaction.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus handshake and datapath enables.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_next = state;
    in_ready   = 1'b0;
    res_valid  = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Adder/subtractor output settles during this cycle; sample at its end.
        capture    = 1'b1;
        state_next = ST_RESULT;
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        // Unused code 2'd3 recovers to IDLE.
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand registers: loaded only on an accepted request in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      au_a <= '0;
      au_b <= '0;
    end else if (load) begin
      au_a <= in_a;
      au_b <= in_b;
    end
  end

  // Result registers: sample the adder/subtractor at the end of SETTLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_data <= '0;
      res_cout <= 1'b0;
      res_v    <= 1'b0;
    end else if (capture) begin
      res_data <= au_sub;
      res_cout <= au_cout;
      res_v    <= au_v;
    end
  end

`ifdef ADDSUB_OVF_COUNT_EN
  // An overflow event is a capture with V set (the SETTLE to RESULT edge).
  addsub_ovf_counter #(
    .CNT_W (CNT_W)
  ) u_ovf_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ovf_clr),
    .inc   (capture & au_v),
    .count (ovf_count)
  );
`else
  // Counter disabled: constant zero, clear input deliberately unused.
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_count      = '0;
`endif

endmodule : addsub_op_sequencer
